// File: rtl/bu_pipe_modq.sv
`default_nettype none
// ============================================================================
// Module   : bu_pipe_modq
// Purpose  : Multi-lane, 4-stage pipelined NTT butterfly modulo a prime Q.
//            Supports Cooley-Tukey, Gentleman-Sande, GS with halving and
//            pass-through. A single global stall freezes every stage
//            while the output beat is not taken.
// Revision : 1.0 - initial release
// ============================================================================
module bu_pipe_modq #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned Q          = 8380417,
  parameter int          LANES      = 2,
  parameter int          TAG_WIDTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [1:0]                  mode_i,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic [LANES*DATA_WIDTH-1:0] w_i,
  input  logic [TAG_WIDTH-1:0]        tag_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LANES*DATA_WIDTH-1:0] a_o,
  output logic [LANES*DATA_WIDTH-1:0] b_o,
  output logic [TAG_WIDTH-1:0]        tag_o,
  output logic                        busy_o
);

  localparam int W = DATA_WIDTH;

  localparam logic [W-1:0]   c_Q  = W'(Q);
  localparam logic [2*W-1:0] c_Q2 = {{W{1'b0}}, c_Q};

  localparam logic [1:0] c_MODE_CT   = 2'b00;
  localparam logic [1:0] c_MODE_GS   = 2'b01;
  localparam logic [1:0] c_MODE_GSH  = 2'b10;
  localparam logic [1:0] c_MODE_PASS = 2'b11;

  // (x + y) mod Q for x, y in [0,Q); the sum cannot overflow W bits because Q < 2^(W-1)
  function automatic logic [W-1:0] f_add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s;
    s = x + y;
    return (s >= c_Q) ? (s - c_Q) : s;
  endfunction

  // (x - y) mod Q; a negative difference wraps and is corrected by adding Q
  function automatic logic [W-1:0] f_sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? (x - y) : (x - y + c_Q);
  endfunction

  // x * 2^-1 mod Q: odd values are made even by adding the (odd) modulus first
  function automatic logic [W-1:0] f_half_mod(input logic [W-1:0] x);
    return x[0] ? ((x + c_Q) >> 1) : (x >> 1);
  endfunction

  // --------------------------------------------------------------------------
  // Control: valid bits, mode and tag travelling with each beat
  // --------------------------------------------------------------------------
  logic                 w_adv;
  logic [3:0]           r_vld;
  logic [1:0]           r_mode [3];
  logic [TAG_WIDTH-1:0] r_tag  [4];

  // Whole pipeline advances unless the output beat is blocked downstream
  assign w_adv   = !(r_vld[3] && !ready_i);
  assign ready_o = w_adv;
  assign valid_o = r_vld[3];
  assign busy_o  = |r_vld;
  assign tag_o   = r_tag[3];

  // Shift valid bits, modes and tags one stage per advancing cycle
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vld <= '0;
      for (int i = 0; i < 3; i++) r_mode[i] <= '0;
      for (int i = 0; i < 4; i++) r_tag[i]  <= '0;
    end else if (w_adv) begin
      r_vld     <= {r_vld[2:0], valid_i};
      r_mode[0] <= mode_i;
      r_tag[0]  <= tag_i;
      for (int i = 1; i < 3; i++) r_mode[i] <= r_mode[i-1];
      for (int i = 1; i < 4; i++) r_tag[i]  <= r_tag[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Per-lane datapath
  //   S1: operand prep (GS sum/difference), S2: full-width product,
  //   S3: exact reduction mod Q, S4: final add/sub/halve and output
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [W-1:0]   w_w;
    logic [W-1:0]   w_s1_a;
    logic [W-1:0]   w_s1_m;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_red;
    logic [W-1:0]   w_s4_a;
    logic [W-1:0]   w_s4_b;

    logic [W-1:0]   r_s1_a;
    logic [W-1:0]   r_s1_m;
    logic [W-1:0]   r_s1_w;
    logic [W-1:0]   r_s2_a;
    logic [W-1:0]   r_s2_m;
    logic [2*W-1:0] r_s2_p;
    logic [W-1:0]   r_s3_a;
    logic [W-1:0]   r_s3_m;
    logic [W-1:0]   r_s3_t;
    logic [W-1:0]   r_s4_a;
    logic [W-1:0]   r_s4_b;

    assign w_a = a_i[g*W +: W];
    assign w_b = b_i[g*W +: W];
    assign w_w = w_i[g*W +: W];

    // GS forms a+b and a-b up front; CT and pass-through forward a and b untouched
    always_comb begin
      w_s1_a = w_a;
      w_s1_m = w_b;
      if (mode_i == c_MODE_GS || mode_i == c_MODE_GSH) begin
        w_s1_a = f_add_mod(w_a, w_b);
        w_s1_m = f_sub_mod(w_a, w_b);
      end
    end

    assign w_prod = {{W{1'b0}}, r_s1_m} * {{W{1'b0}}, r_s1_w};
    assign w_red  = W'(r_s2_p % c_Q2);

    // Final combine selected by the mode of the beat sitting in stage 3
    always_comb begin
      w_s4_a = r_s3_a;
      w_s4_b = r_s3_t;
      case (r_mode[2])
        c_MODE_CT: begin
          w_s4_a = f_add_mod(r_s3_a, r_s3_t);
          w_s4_b = f_sub_mod(r_s3_a, r_s3_t);
        end
        c_MODE_GS: begin
          w_s4_a = r_s3_a;
          w_s4_b = r_s3_t;
        end
        c_MODE_GSH: begin
          w_s4_a = f_half_mod(r_s3_a);
          w_s4_b = f_half_mod(r_s3_t);
        end
        c_MODE_PASS: begin
          w_s4_a = r_s3_a;
          w_s4_b = r_s3_m;
        end
        default: begin
          w_s4_a = r_s3_a;
          w_s4_b = r_s3_t;
        end
      endcase
    end

    // Lane data registers; cleared on reset so outputs read zero
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        r_s1_a <= '0;
        r_s1_m <= '0;
        r_s1_w <= '0;
        r_s2_a <= '0;
        r_s2_m <= '0;
        r_s2_p <= '0;
        r_s3_a <= '0;
        r_s3_m <= '0;
        r_s3_t <= '0;
        r_s4_a <= '0;
        r_s4_b <= '0;
      end else if (w_adv) begin
        r_s1_a <= w_s1_a;
        r_s1_m <= w_s1_m;
        r_s1_w <= w_w;
        r_s2_a <= r_s1_a;
        r_s2_m <= r_s1_m;
        r_s2_p <= w_prod;
        r_s3_a <= r_s2_a;
        r_s3_m <= r_s2_m;
        r_s3_t <= w_red;
        r_s4_a <= w_s4_a;
        r_s4_b <= w_s4_b;
      end
    end

    assign a_o[g*W +: W] = r_s4_a;
    assign b_o[g*W +: W] = r_s4_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_bu_pipe_modq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bu_pipe_modq
// Purpose  : Self-checking bench for bu_pipe_modq (Q = 8380417, 2 lanes).
//            Table of hand-computed butterfly vectors plus streaming/stall
//            and mid-flight reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bu_pipe_modq;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int TW = 8;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      mode_i;
  logic [L*W-1:0]  a_i;
  logic [L*W-1:0]  b_i;
  logic [L*W-1:0]  w_i;
  logic [TW-1:0]   tag_i;
  logic            valid_o;
  logic            ready_i;
  logic [L*W-1:0]  a_o;
  logic [L*W-1:0]  b_o;
  logic [TW-1:0]   tag_o;
  logic            busy_o;

  bu_pipe_modq #(
    .DATA_WIDTH (W),
    .Q          (8380417),
    .LANES      (L),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mode_i   (mode_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .w_i      (w_i),
    .tag_i    (tag_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .a_o      (a_o),
    .b_o      (b_o),
    .tag_o    (tag_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
    logic [63:0] ea;
    logic [63:0] eb;
  } vec_t;

  vec_t vecs [8];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [63:0] pk(input logic [31:0] l1, input logic [31:0] l0);
    return {l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h (%0d) expected 0x%h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int i, input logic [TW-1:0] tag);
    valid_i = 1'b1;
    mode_i  = vecs[i].mode;
    a_i     = vecs[i].a;
    b_i     = vecs[i].b;
    w_i     = vecs[i].w;
    tag_i   = tag;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    mode_i  = 2'b00;
    a_i     = '0;
    b_i     = '0;
    w_i     = '0;
    tag_i   = '0;
  endtask

  // Send one beat into an empty pipe, check latency (edges incl. acceptance) and data
  task automatic single(input int i, input logic [TW-1:0] tag);
    int n;
    drive(i, tag);
    tick();
    idle();
    n = 1;
    while (!valid_o && n < 12) begin
      tick();
      n++;
    end
    check($sformatf("latency_v%0d", i), 64'(n), 64'd4);
    check($sformatf("a_o_v%0d", i), a_o, vecs[i].ea);
    check($sformatf("b_o_v%0d", i), b_o, vecs[i].eb);
    check($sformatf("tag_o_v%0d", i), 64'(tag_o), 64'(tag));
    tick();
  endtask

  initial begin
    int sent;
    int rx;
    int stale;
    logic stall;

    // lane1, lane0 packed; Q = 8380417, Q-1 = 8380416
    vecs[0] = '{2'b00, pk(0, 1), pk(8380416, 2), pk(8380416, 3),
                pk(1, 7), pk(8380416, 8380412)};
    vecs[1] = '{2'b01, pk(3, 5), pk(5, 3), pk(2, 10),
                pk(8, 8), pk(8380413, 20)};
    vecs[2] = '{2'b10, pk(2, 5), pk(1, 3), pk(1, 10),
                pk(4190210, 4), pk(4190209, 10)};
    vecs[3] = '{2'b11, pk(8380416, 123), pk(0, 456), pk(7, 9),
                pk(8380416, 123), pk(0, 456)};
    vecs[4] = '{2'b00, pk(0, 8380416), pk(0, 1), pk(5, 1),
                pk(0, 0), pk(0, 8380415)};
    vecs[5] = '{2'b01, pk(8380416, 0), pk(8380416, 8380416), pk(7, 8380416),
                pk(8380415, 8380416), pk(0, 8380416)};
    vecs[6] = '{2'b00, pk(20000, 10), pk(4, 2048), pk(4194304, 4096),
                pk(36382, 8201), pk(3618, 8372236)};
    vecs[7] = '{2'b10, pk(0, 4), pk(0, 2), pk(0, 3),
                pk(0, 3), pk(0, 3)};

    // Reset state
    reset_ni = 1'b0;
    ready_i  = 1'b1;
    idle();
    tick();
    tick();
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_busy_o",  64'(busy_o),  64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_a_o",     a_o,          64'd0);
    check("rst_b_o",     b_o,          64'd0);
    check("rst_tag_o",   64'(tag_o),   64'd0);
    reset_ni = 1'b1;
    tick();

    // Table of single beats
    for (int i = 0; i < 8; i++) single(i, 8'(8'hA0 + i));

    // Back-to-back stream of mixed modes with a 3-cycle downstream stall
    sent = 0;
    rx   = 0;
    for (int c = 0; c < 40; c++) begin
      stall   = (c >= 6 && c <= 8);
      ready_i = !stall;
      if (sent < 8) drive(sent, 8'(sent));
      else          idle();
      #1;
      check($sformatf("stream_ready_o_c%0d", c), 64'(ready_o), 64'(!stall));
      if (valid_i && ready_o) sent++;
      if (valid_o && ready_i) begin
        if (rx < 8) begin
          check($sformatf("stream_tag_%0d", rx), 64'(tag_o), 64'(rx));
          check($sformatf("stream_a_%0d", rx), a_o, vecs[rx].ea);
          check($sformatf("stream_b_%0d", rx), b_o, vecs[rx].eb);
        end
        rx++;
      end
      tick();
    end
    idle();
    ready_i = 1'b1;
    check("stream_count", 64'(rx), 64'd8);
    check("stream_busy_end", 64'(busy_o), 64'd0);

    // Reset with three beats in flight, one of them on the output
    for (int k = 0; k < 3; k++) begin
      drive(k, 8'(8'h10 + k));
      tick();
    end
    idle();
    tick();
    check("pre_rst_valid_o", 64'(valid_o), 64'd1);
    check("pre_rst_busy_o",  64'(busy_o),  64'd1);
    reset_ni = 1'b0;
    #1;
    check("mid_rst_valid_o", 64'(valid_o), 64'd0);
    check("mid_rst_busy_o",  64'(busy_o),  64'd0);
    check("mid_rst_ready_o", 64'(ready_o), 64'd1);
    tick();
    tick();
    reset_ni = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid_o || busy_o) stale++;
    end
    check("post_rst_stale", 64'(stale), 64'd0);

    // First beat after reset release keeps the nominal latency
    single(6, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
